// File: rtl/serial_tx_buffered.sv
// serial_tx_buffered: 8N1 UART transmitter fed by a small FIFO, with a block input that holds off new frames
module serial_tx_buffered #(
    parameter int CLK_PER_BIT = 50,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       new_data,
    input  logic       block,
    output logic       full,
    output logic       busy,
    output logic       tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CLK_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [7:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic full_q, busy_q, tx_q, tx_d;
    logic wr, pop, bit_end, can_start;
    assign wr = new_data && !full_q;
    assign bit_end = timer_q == TW'(CLK_PER_BIT - 1);
    assign can_start = count_q != '0 && !block;
    assign full = full_q;
    assign busy = busy_q;
    assign tx = tx_q;
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        idx_d = idx_q;
        shift_d = shift_q;
        pop = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (can_start) begin
                    pop = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                timer_d = '0;
                idx_d = '0;
                state_d = DATA;
            end
            DATA: if (bit_end) begin
                timer_d = '0;
                shift_d = shift_q >> 1;
                idx_d = idx_q + 3'd1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (bit_end) begin
                timer_d = '0;
                pop = can_start;
                shift_d = can_start ? mem_q[rptr_q] : shift_q;
                state_d = can_start ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
        count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
            timer_q <= '0;
            idx_q <= '0;
            shift_q <= '0;
            full_q <= 1'b0;
            busy_q <= 1'b0;
            tx_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wptr_q <= wr ? wptr_q + 1'b1 : wptr_q;
            rptr_q <= pop ? rptr_q + 1'b1 : rptr_q;
            count_q <= count_d;
            timer_q <= timer_d;
            idx_q <= idx_d;
            shift_q <= shift_d;
            full_q <= count_d == (AW+1)'(DEPTH);
            busy_q <= state_d != IDLE || count_d != '0;
            tx_q <= tx_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= data;
    end
endmodule

// File: doc/serial_tx_buffered.md
# serial_tx_buffered

Buffered 8N1 UART transmitter for the Mojo base design. It is the transmit-side counterpart to the board's serial receive path. Bytes are pushed through a one-cycle strobe into a small FIFO and then shifted out on `tx`, LSB first, at a fixed clocks-per-bit rate. A `block` input stalls the start of new frames so the AVR flow control can hold off transmission without losing queued bytes.

## Interface
- `CLK_PER_BIT`, 50: clock cycles per UART bit (50 MHz / 1 Mbaud); legal range ≥ 2.
- `DEPTH`, 4: FIFO entries; must be a power of 2, ≥ 2.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low (sampled on the `clk` rising edge).
- `data`  in  8  byte to enqueue; sampled when `new_data`=1.
- `new_data`  in  1  write strobe; one byte per cycle high.
- `block`  in  1  when 1, no new frame starts; a frame already in progress completes.
- `full`  out  1  FIFO holds DEPTH entries; writes are dropped while high.
- `busy`  out  1  high when a frame is in progress or the FIFO is non-empty.
- `tx`  out  1  serial line, idle high, registered output.

## Operation
- FIFO:
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - A write is accepted iff `new_data`=1 and `full`=0 at that edge.
  - `full` is the registered count==DEPTH. A pop in the same cycle does not admit a write while `full`=1.
  - Simultaneous accepted write and pop leaves the count unchanged.
- Transmit FSM, states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty and `block`=0, pop the head into an 8-bit shift register, clear the bit-timer and go to START. Otherwise hold, `tx`=1.
  - START: `tx`=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLK_PER_BIT cycles per bit, shift right, index 0..7. After bit 7 go to STOP.
  - STOP: `tx`=1 for CLK_PER_BIT cycles. At the end, if FIFO non-empty and `block`=0, pop and go directly to START (back-to-back frames, no extra idle cycle). Otherwise go to IDLE.
- The bit-timer counts 0..CLK_PER_BIT-1 with width clog2(CLK_PER_BIT). It reloads to 0 on every state or bit change.
- `block` is sampled only at frame-start decision points. Asserting it mid-frame has no effect on that frame.
- `busy` = (state≠IDLE) or (count≠0), registered.
- Data bytes are transmitted unmodified, in FIFO order. Exactly 10 bit-times per frame.

## Timing
- Reset (`rst_n`=0 at an edge) gives:
  - `tx`=1, `busy`=0, `full`=0
  - state IDLE, count 0, pointers 0, bit-timer 0
- Reset mid-frame truncates the frame: `tx` is high from the next cycle and queued bytes are discarded.
- Write latency, for an empty FIFO in IDLE with `block`=0:
  - `new_data` is high in cycle 0.
  - The entry is visible in cycle 1.
  - The pop happens at the edge ending cycle 1, and `tx` goes low in cycle 2.
- Frame duration is exactly 10·CLK_PER_BIT cycles from `tx` falling to the end of the stop bit.
- `full` rises in the cycle after the accepted write that makes count==DEPTH. It falls the cycle after a pop.
- `busy` falls in the first cycle after STOP ends, provided the FIFO is empty and no write was accepted at that edge.

## Test plan
- **Single byte.** CLK_PER_BIT=4, write 0xA5 → `tx` low in cycle 2, then 4-cycle bits 1,0,1,0,0,1,0,1, then stop high. `busy` high through cycle 41 and low at cycle 42.
- **Back-to-back.** Write 0x00, 0xFF, 0x3C on consecutive cycles → three contiguous 40-cycle frames. No idle gap between stop and the next start; the bytes are received in order.
- **Overflow.** DEPTH=4, `block`=1, write 0x01..0x06 → `full`=1 after the 4th write, and 0x05/0x06 are dropped. Release `block` → exactly 0x01..0x04 are transmitted.
- **Block timing.** Assert `block` mid-frame of 0x55 → that frame completes and a queued 0x66 waits, `tx` high. Deassert `block` → 0x66 starts the next cycle.
- **Reset mid-frame.** Pull `rst_n` low during DATA bit 3 with 2 bytes queued → next cycle `tx`=1, `busy`=0, `full`=0. No further frames until new writes.
- **Pointer wrap.** DEPTH=4, send 10 bytes 0x10..0x19 in bursts of 3 with `full` respected → all 10 bytes are sent in order. Same-cycle write+pop keeps the count correct.
